// File: rtl/serial_frame_ctrl_if.sv
// serial_frame_ctrl_if: serial bit input and frame result bundle for serial_frame_ctrl.
// The master side drives the serial bit stream. The slave side (the controller) reports state and frame results.
interface serial_frame_ctrl_if;
  logic       in_i;
  logic       in_vld_i;
  logic [2:0] state_o;
  logic       seq_sat_o;
  logic       addr_sat_o;
  logic [7:0] data_out_o;
  logic [3:0] crc_out_o;
  logic       frame_vld_o;
  logic       crc_err_o;
  logic       abort_o;

  modport master (
    output in_i, in_vld_i,
    input  state_o, seq_sat_o, addr_sat_o, data_out_o, crc_out_o,
           frame_vld_o, crc_err_o, abort_o
  );

  modport slave (
    input  in_i, in_vld_i,
    output state_o, seq_sat_o, addr_sat_o, data_out_o, crc_out_o,
           frame_vld_o, crc_err_o, abort_o
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: receive sequencer for a single-bit serial stream.
// A frame is laid out as follows:
//   8-bit preamble (SYNC_PAT), 4-bit address (must equal MY_ADDR),
//   8-bit data, then a 4-bit CRC (x^4+x+1).
// All fields are sent MSB first.
// Each complete frame produces a one-cycle frame_vld pulse with the captured byte and the CRC check result.
// Optional feature: define FRAME_TIMEOUT_EN to abort a frame after TIMEOUT bit-less cycles.
// Without that macro, abort is tied low and the FSM waits for bits indefinitely.
module serial_frame_ctrl #(
  parameter logic [7:0] SYNC_PAT = 8'hB1,
  parameter logic [3:0] MY_ADDR  = 4'h5
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  serial_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    CRC  = 3'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] win_q, win_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] crc_q, crc_d;
  logic [7:0] dataCap_q, dataCap_d;
  logic [7:0] dataOut_q, dataOut_d;
  logic [3:0] crcOut_q, crcOut_d;
  logic       crcErr_q, crcErr_d;
  logic       frameVld_q, frameVld_d;

  logic [7:0] winNext;
  logic       crcFb;
  logic [3:0] crcStep;
  logic       timeoutHit;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  logic [IdleW-1:0] idleCnt_q, idleCnt_d;
  logic             abort_q;

  // Count consecutive bit-less cycles inside a frame; a full count forces the frame to be dropped
  always_comb begin
    timeoutHit = (state_q != IDLE) && (idleCnt_q == IdleW'(TIMEOUT));
    if ((state_q == IDLE) || bus.in_vld_i || timeoutHit) begin
      idleCnt_d = '0;
    end else begin
      idleCnt_d = idleCnt_q + 1'b1;
    end
  end

  // Idle counter and one-cycle abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idleCnt_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      idleCnt_q <= idleCnt_d;
      abort_q   <= timeoutHit;
    end
  end

  assign bus.abort_o = abort_q;
`else
  assign timeoutHit  = 1'b0;
  assign bus.abort_o = 1'b0;
`endif

  // Next-state logic for sequencing: preamble hunt, address match, data capture with serial CRC, CRC compare
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    dataCap_d  = dataCap_q;
    dataOut_d  = dataOut_q;
    crcOut_d   = crcOut_q;
    crcErr_d   = crcErr_q;
    frameVld_d = 1'b0;

    winNext = {win_q[6:0], bus.in_i};
    crcFb   = crc_q[3] ^ bus.in_i;
    crcStep = {crc_q[2:0], 1'b0} ^ (crcFb ? 4'h3 : 4'h0);

    if (timeoutHit) begin
      state_d = IDLE;
      win_d   = '0;
      cnt_d   = '0;
    end else if (bus.in_vld_i) begin
      case (state_q)
        IDLE: begin
          win_d = winNext;
          cnt_d = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
          if ((cnt_q >= 4'd7) && (winNext == SYNC_PAT)) begin
            state_d = ADDR;
            win_d   = '0;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          win_d = winNext;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            win_d = '0;
            cnt_d = '0;
            if (winNext[3:0] == MY_ADDR) begin
              state_d = DATA;
              crc_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          win_d = winNext;
          cnt_d = cnt_q + 4'd1;
          crc_d = crcStep;
          if (cnt_q == 4'd7) begin
            state_d   = CRC;
            dataCap_d = winNext;
            win_d     = '0;
            cnt_d     = '0;
          end
        end
        CRC: begin
          win_d = winNext;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            state_d    = IDLE;
            win_d      = '0;
            cnt_d      = '0;
            dataOut_d  = dataCap_q;
            crcOut_d   = crc_q;
            crcErr_d   = (winNext[3:0] != crc_q);
            frameVld_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          win_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any frame in progress without reporting it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      crc_q      <= '0;
      dataCap_q  <= '0;
      dataOut_q  <= '0;
      crcOut_q   <= '0;
      crcErr_q   <= 1'b0;
      frameVld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      dataCap_q  <= dataCap_d;
      dataOut_q  <= dataOut_d;
      crcOut_q   <= crcOut_d;
      crcErr_q   <= crcErr_d;
      frameVld_q <= frameVld_d;
    end
  end

  assign bus.state_o     = state_q;
  assign bus.seq_sat_o   = (state_q == ADDR) || (state_q == DATA) || (state_q == CRC);
  assign bus.addr_sat_o  = (state_q == DATA) || (state_q == CRC);
  assign bus.data_out_o  = dataOut_q;
  assign bus.crc_out_o   = crcOut_q;
  assign bus.frame_vld_o = frameVld_q;
  assign bus.crc_err_o   = crcErr_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb_serial_frame_ctrl: directed testbench for serial_frame_ctrl using hand-computed frames.
// Inputs change at the falling edge. Outputs are sampled at the falling edge after each rising edge.
// CRCs are hand-computed: A5 gives B, 3C gives 8, and FF gives 4.
module tb_serial_frame_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_frame_ctrl_if bus();

  serial_frame_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic vld, input logic b);
    bus.in_vld_i = vld;
    bus.in_i     = b;
    @(negedge clk);
  endtask

  task automatic sendBits(input logic [7:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, val[i]);
  endtask

  task automatic sendGap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic sendFrame(input logic [3:0] addr, input logic [7:0] data, input logic [3:0] crc);
    sendBits(8'hB1, 8);
    sendBits({4'h0, addr}, 4);
    sendBits(data, 8);
    sendBits({4'h0, crc}, 4);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    rst = 1'b0;
    total++; if (bus.state_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", bus.state_o); end
    total++; if (bus.data_out_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00", bus.data_out_o); end
    total++; if (bus.crc_out_o !== 4'h0) begin bad++; $display("[TB] FAIL reset_crc got=%h exp=0", bus.crc_out_o); end
    total++; if ({bus.seq_sat_o, bus.addr_sat_o, bus.frame_vld_o, bus.crc_err_o, bus.abort_o} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=00000",
        {bus.seq_sat_o, bus.addr_sat_o, bus.frame_vld_o, bus.crc_err_o, bus.abort_o});
    end
  endtask

  task automatic test_clean;
    sendBits(8'hB1, 8);
    total++; if ({bus.state_o, bus.seq_sat_o, bus.addr_sat_o} !== {3'd1, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL clean_lock got=%b exp=00110", {bus.state_o, bus.seq_sat_o, bus.addr_sat_o});
    end
    sendBits(8'h05, 4);
    total++; if ({bus.state_o, bus.seq_sat_o, bus.addr_sat_o} !== {3'd2, 1'b1, 1'b1}) begin
      bad++; $display("[TB] FAIL clean_addr got=%b exp=01011", {bus.state_o, bus.seq_sat_o, bus.addr_sat_o});
    end
    sendBits(8'hA5, 8);
    total++; if ((bus.state_o !== 3'd3) || (bus.frame_vld_o !== 1'b0)) begin
      bad++; $display("[TB] FAIL clean_data state=%0d vld=%b exp state=3 vld=0", bus.state_o, bus.frame_vld_o);
    end
    sendBits(8'h0B, 4);
    total++; if (bus.frame_vld_o !== 1'b1) begin bad++; $display("[TB] FAIL clean_vld got=%b exp=1", bus.frame_vld_o); end
    total++; if (bus.data_out_o !== 8'hA5) begin bad++; $display("[TB] FAIL clean_data_out got=%h exp=a5", bus.data_out_o); end
    total++; if (bus.crc_out_o !== 4'hB) begin bad++; $display("[TB] FAIL clean_crc got=%h exp=b", bus.crc_out_o); end
    total++; if ((bus.crc_err_o !== 1'b0) || (bus.state_o !== 3'd0) || (bus.seq_sat_o !== 1'b0)) begin
      bad++; $display("[TB] FAIL clean_end err=%b state=%0d seq=%b exp 0/0/0", bus.crc_err_o, bus.state_o, bus.seq_sat_o);
    end
    step(1'b0, 1'b0);
    total++; if (bus.frame_vld_o !== 1'b0) begin bad++; $display("[TB] FAIL clean_pulse got=%b exp=0", bus.frame_vld_o); end
  endtask

  task automatic test_corrupt_crc;
    sendFrame(4'h5, 8'hA5, 4'hA);
    total++; if ({bus.frame_vld_o, bus.crc_err_o} !== 2'b11) begin
      bad++; $display("[TB] FAIL corrupt_flags got=%b exp=11", {bus.frame_vld_o, bus.crc_err_o});
    end
    total++; if ((bus.data_out_o !== 8'hA5) || (bus.crc_out_o !== 4'hB)) begin
      bad++; $display("[TB] FAIL corrupt_data got=%h/%h exp=a5/b", bus.data_out_o, bus.crc_out_o);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_addr_miss;
    logic [11:0] junk;
    int          pulses;
    junk   = 12'hA5B;
    pulses = 0;
    sendBits(8'hB1, 8);
    sendBits(8'h03, 4);
    total++; if (bus.state_o !== 3'd0) begin bad++; $display("[TB] FAIL miss_state got=%0d exp=0", bus.state_o); end
    for (int i = 11; i >= 0; i--) begin
      step(1'b1, junk[i]);
      if (bus.frame_vld_o === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL miss_pulses got=%0d exp=0", pulses); end
    total++; if (bus.data_out_o !== 8'hA5) begin bad++; $display("[TB] FAIL miss_data got=%h exp=a5", bus.data_out_o); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] frame2;
    int          pulses;
    int          pulseAt;
    frame2  = {8'hB1, 4'h5, 8'hFF, 4'h4};
    pulses  = 0;
    pulseAt = -1;
    sendBits(8'h0D, 5);
    sendBits(8'h58, 7);
    total++; if (bus.state_o !== 3'd0) begin bad++; $display("[TB] FAIL hunt_early got=%0d exp=0", bus.state_o); end
    sendBits(8'h01, 1);
    total++; if (bus.state_o !== 3'd1) begin bad++; $display("[TB] FAIL hunt_lock got=%0d exp=1", bus.state_o); end
    sendBits(8'h05, 4);
    sendBits(8'h3C, 8);
    sendBits(8'h08, 4);
    total++; if ({bus.frame_vld_o, bus.crc_err_o, bus.data_out_o, bus.crc_out_o} !== {2'b10, 8'h3C, 4'h8}) begin
      bad++; $display("[TB] FAIL b2b_first got=%b_%h_%h exp=10_3c_8",
        {bus.frame_vld_o, bus.crc_err_o}, bus.data_out_o, bus.crc_out_o);
    end
    for (int i = 23; i >= 0; i--) begin
      step(1'b1, frame2[i]);
      if (bus.frame_vld_o === 1'b1) begin
        pulses++;
        if (pulseAt < 0) pulseAt = 24 - i;
      end
    end
    total++; if ((pulses !== 1) || (pulseAt !== 24)) begin
      bad++; $display("[TB] FAIL b2b_spacing pulses=%0d at=%0d exp 1 at 24", pulses, pulseAt);
    end
    total++; if ({bus.crc_err_o, bus.data_out_o, bus.crc_out_o} !== {1'b0, 8'hFF, 4'h4}) begin
      bad++; $display("[TB] FAIL b2b_second got=%b_%h_%h exp=0_ff_4", bus.crc_err_o, bus.data_out_o, bus.crc_out_o);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_gap;
    int gapLen;
`ifdef FRAME_TIMEOUT_EN
    gapLen = 10;
`else
    gapLen = 40;
`endif
    sendBits(8'hB1, 8);
    sendBits(8'h05, 4);
    sendBits(8'h0A, 4);
    sendGap(gapLen);
    total++; if ({bus.state_o, bus.abort_o} !== {3'd2, 1'b0}) begin
      bad++; $display("[TB] FAIL gap_hold state=%0d abort=%b exp 2/0", bus.state_o, bus.abort_o);
    end
    sendBits(8'h05, 4);
    sendBits(8'h0B, 4);
    total++; if ({bus.frame_vld_o, bus.crc_err_o, bus.data_out_o} !== {2'b10, 8'hA5}) begin
      bad++; $display("[TB] FAIL gap_frame got=%b_%h exp=10_a5", {bus.frame_vld_o, bus.crc_err_o}, bus.data_out_o);
    end
    step(1'b0, 1'b0);
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout;
    sendBits(8'hB1, 8);
    sendBits(8'h05, 4);
    sendBits(8'h03, 4);
    sendGap(16);
    total++; if ({bus.state_o, bus.abort_o} !== {3'd2, 1'b0}) begin
      bad++; $display("[TB] FAIL timeout_pre state=%0d abort=%b exp 2/0", bus.state_o, bus.abort_o);
    end
    step(1'b1, 1'b1);
    total++; if ({bus.abort_o, bus.frame_vld_o, bus.state_o} !== {2'b10, 3'd0}) begin
      bad++; $display("[TB] FAIL timeout_abort got=%b exp=10000", {bus.abort_o, bus.frame_vld_o, bus.state_o});
    end
    step(1'b0, 1'b0);
    total++; if ((bus.abort_o !== 1'b0) || (bus.data_out_o !== 8'hA5)) begin
      bad++; $display("[TB] FAIL timeout_after abort=%b data=%h exp 0/a5", bus.abort_o, bus.data_out_o);
    end
  endtask
`endif

  task automatic test_reset_mid;
    sendBits(8'hB1, 8);
    sendBits(8'h05, 4);
    sendBits(8'h0C, 4);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    total++; if ({bus.state_o, bus.data_out_o, bus.crc_out_o} !== 15'd0) begin
      bad++; $display("[TB] FAIL rstmid_regs got=%0d_%h_%h exp=0_00_0", bus.state_o, bus.data_out_o, bus.crc_out_o);
    end
    total++; if ({bus.seq_sat_o, bus.addr_sat_o, bus.frame_vld_o, bus.crc_err_o, bus.abort_o} !== 5'b0) begin
      bad++; $display("[TB] FAIL rstmid_flags got=%b exp=00000",
        {bus.seq_sat_o, bus.addr_sat_o, bus.frame_vld_o, bus.crc_err_o, bus.abort_o});
    end
    sendFrame(4'h5, 8'h3C, 4'h8);
    total++; if ({bus.frame_vld_o, bus.crc_err_o, bus.data_out_o, bus.crc_out_o} !== {2'b10, 8'h3C, 4'h8}) begin
      bad++; $display("[TB] FAIL rstmid_frame got=%b_%h_%h exp=10_3c_8",
        {bus.frame_vld_o, bus.crc_err_o}, bus.data_out_o, bus.crc_out_o);
    end
    step(1'b0, 1'b0);
  endtask

  // Run every scenario in order, then report
  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.in_i     = 1'b0;
    bus.in_vld_i = 1'b0;
    @(negedge clk);
    test_reset;
    test_clean;
    test_corrupt_crc;
    test_addr_miss;
    test_back_to_back;
    test_gap;
`ifdef FRAME_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Controller and sequencer for the serial receive path: single-bit stream, sync-pattern detect, address match, 8-bit data capture, CRC-4 check. One FSM with explicit, cycle-exact state replaces ad hoc reset chaining between stages, and reports each frame as a one-cycle result with a checked CRC. Sits between the serial pin and any consumer of captured bytes.

## Interface
- SYNC_PAT, 8'hB1: preamble, MSB first
- MY_ADDR, 4'h5: accepted station address
- TIMEOUT, 16: idle-bit cycles before abort (only with FRAME_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in  in  1  serial data bit
- in_vld  in  1  `in` is a valid bit this cycle
- state  out  3  FSM state: IDLE=0, ADDR=1, DATA=2, CRC=3
- seq_sat  out  1  high while state is ADDR, DATA or CRC
- addr_sat  out  1  high while state is DATA or CRC
- data_out  out  8  last captured byte, held until next frame_vld
- crc_out  out  4  CRC computed over data_out
- frame_vld  out  1  one-cycle pulse: frame complete
- crc_err  out  1  valid with frame_vld: received CRC differs from crc_out
- abort  out  1  one-cycle pulse: frame dropped by timeout

## Operation
- A bit is consumed only on an edge where in_vld=1. All fields are MSB first.
- IDLE
  - Shift into 8-bit window `win`.
  - Bit counter saturates at 8.
  - When the counter is ≥7 and {win[6:0],in}==SYNC_PAT: go to ADDR on that edge.
- ADDR
  - Collect 4 bits.
  - On the 4th bit: match with MY_ADDR goes to DATA; mismatch goes to IDLE.
- DATA
  - Collect 8 bits into a shift register.
  - Run CRC serially on each bit: fb=crc[3]^in; crc={crc[2:0],1'b0}^(fb?4'h3:4'h0).
  - CRC is x^4+x+1, init 0 at ADDR→DATA.
  - On the 8th bit: go to CRC.
- CRC
  - Collect 4 received bits.
  - On the 4th bit, at that edge:
    - Go to IDLE.
    - Register data_out, crc_out and crc_err.
    - Set frame_vld for the next cycle.
- Every entry to IDLE clears `win` and the bit counter, so a new preamble always needs 8 fresh bits.
- An address mismatch produces no frame_vld and leaves data_out unchanged.

## Timing
- Reset values, after any edge with rst=1:
  - state=IDLE; win, counter and CRC register cleared.
  - Outputs: seq_sat=0, addr_sat=0, data_out=0, crc_out=0, frame_vld=0, crc_err=0, abort=0.
- rst mid-frame discards the frame silently: no frame_vld, no abort.
- seq_sat and addr_sat are decoded from the registered state, so they change one cycle after the qualifying edge.
- Minimum frame is 24 valid bits: 8 preamble, 4 address, 8 data, 4 CRC.
- Latency: frame_vld is high in the cycle following the edge that samples the last CRC bit.
- frame_vld and abort never assert together.
- Back-to-back frames:
  - A bit presented in the cycle frame_vld is high is already consumed by IDLE.
  - Full throughput is one frame per 24 valid bits.
- in_vld gaps of any length (macro off) do not disturb state.
- rst has priority over all other events.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - An idle counter increments each cycle with in_vld=0 while state≠IDLE.
  - It clears on any valid bit or in IDLE.
  - When it reaches TIMEOUT: go to IDLE, pulse abort for one cycle, no frame_vld.
  - A valid bit on the TIMEOUT-th edge is ignored; the abort still occurs.
- Undefined:
  - No idle counter; abort is tied 0.
  - The FSM waits indefinitely for bits.

## Test plan
- Clean frame: B1, 5, A5, B, in_vld=1 throughout → one frame_vld pulse 1 cycle after the 24th bit; data_out=8'hA5, crc_out=4'hB, crc_err=0.
- Corrupt CRC: same frame with CRC nibble 4'hA → frame_vld=1, crc_err=1, data_out=8'hA5.
- Address miss: B1, 3, A5, B → state returns to IDLE after the address nibble; no frame_vld; data_out keeps its prior value.
- Preamble hunt: random leading bits, then B1 in the middle of the stream → lock exactly on the last preamble bit; two back-to-back valid frames give two frame_vld pulses 24 bits apart.
- Gaps and timeout (macro on, TIMEOUT=16): 10-cycle in_vld gap mid-DATA → frame completes normally; 16-cycle gap → abort pulse, state=IDLE, no frame_vld.
- Reset mid-DATA: rst=1 for one cycle → next cycle state=0 and all outputs 0; a following full frame is received correctly.
